// File: rtl/vid_pll_supervisor.sv
`default_nettype none
// ============================================================================
// Module      : vid_pll_supervisor
// Description : Per-PLL lock supervisor for the video clocking subsystem.
//               Holds each PLL in reset at start-up, qualifies its locked
//               output over a stability window, and re-locks automatically
//               on lock loss, timeout or software request.
// Ports       : refclk       - free-running reference clock
//               rst          - synchronous active-high reset
//               pll_locked   - raw PLL locked outputs (asynchronous)
//               relock_req   - per-channel single-cycle re-lock request
//               err_clr      - clears all timeout_err bits
//               pll_rst      - per-PLL reset, active-high
//               clk_ready    - per-channel clock qualified
//               all_ready    - AND of all clk_ready bits
//               loss_count   - per-channel saturating lock-loss counters
//               timeout_err  - per-channel sticky timeout flags
// Revision    : 1.0 - initial release
// ============================================================================
module vid_pll_supervisor #(
    parameter int NUM_PLLS            = 1,
    parameter int RST_CYCLES          = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int CNT_W               = 8
) (
    input  logic                      refclk,
    input  logic                      rst,
    input  logic [NUM_PLLS-1:0]       pll_locked,
    input  logic [NUM_PLLS-1:0]       relock_req,
    input  logic                      err_clr,
    output logic [NUM_PLLS-1:0]       pll_rst,
    output logic [NUM_PLLS-1:0]       clk_ready,
    output logic                      all_ready,
    output logic [NUM_PLLS*CNT_W-1:0] loss_count,
    output logic [NUM_PLLS-1:0]       timeout_err
);

    // One counter serves both the reset-hold window and the stability window.
    localparam int c_CNT_MAX = (RST_CYCLES > LOCK_STABLE_CYCLES) ? RST_CYCLES : LOCK_STABLE_CYCLES;
    localparam int c_CW      = $clog2(c_CNT_MAX);
    localparam int c_TW      = $clog2(LOCK_TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        S_HOLD      = 2'd0,
        S_WAIT_LOCK = 2'd1,
        S_STABLE    = 2'd2,
        S_READY     = 2'd3
    } state_t;

    // Two-flop synchronizer for the asynchronous locked inputs.
    logic [NUM_PLLS-1:0] r_meta;
    logic [NUM_PLLS-1:0] r_lk;

    always_ff @(posedge refclk) begin
        if (rst) begin
            r_meta <= '0;
            r_lk   <= '0;
        end else begin
            r_meta <= pll_locked;
            r_lk   <= r_meta;
        end
    end

    for (genvar g = 0; g < NUM_PLLS; g++) begin : g_chan
        state_t            r_state;
        logic [c_CW-1:0]   r_cnt;
        logic [c_TW-1:0]   r_to_cnt;
        logic              r_pll_rst;
        logic              r_ready;
        logic              r_err;
        logic [CNT_W-1:0]  r_loss;
        logic              w_timeout_hit;
        logic              w_to_hold;

        assign w_timeout_hit = ((r_state == S_WAIT_LOCK) || (r_state == S_STABLE)) &&
                               (r_to_cnt == c_TW'(LOCK_TIMEOUT_CYCLES - 1));

        // Every condition that sends the channel back to HOLD.
        always_comb begin
            w_to_hold = 1'b0;
            case (r_state)
                S_WAIT_LOCK, S_STABLE: w_to_hold = w_timeout_hit | relock_req[g];
                S_READY:               w_to_hold = ~r_lk[g] | relock_req[g];
                default:               w_to_hold = 1'b0;
            endcase
        end

        always_ff @(posedge refclk) begin
            if (rst) begin
                r_state   <= S_HOLD;
                r_cnt     <= '0;
                r_to_cnt  <= '0;
                r_pll_rst <= 1'b1;
                r_ready   <= 1'b0;
                r_err     <= 1'b0;
                r_loss    <= '0;
            end else begin
                // A timeout in the same cycle as err_clr keeps the flag set.
                if (err_clr)       r_err <= 1'b0;
                if (w_timeout_hit) r_err <= 1'b1;

                if (w_to_hold) begin
                    r_state   <= S_HOLD;
                    r_cnt     <= '0;
                    r_to_cnt  <= '0;
                    r_pll_rst <= 1'b1;
                    r_ready   <= 1'b0;
                    // Only a genuine lock loss counts, even if a request coincides.
                    if ((r_state == S_READY) && !r_lk[g] && (r_loss != '1))
                        r_loss <= r_loss + 1'b1;
                end else begin
                    case (r_state)
                        S_HOLD: begin
                            if (r_cnt == c_CW'(RST_CYCLES - 1)) begin
                                r_state   <= S_WAIT_LOCK;
                                r_cnt     <= '0;
                                r_pll_rst <= 1'b0;
                            end else begin
                                r_cnt <= r_cnt + 1'b1;
                            end
                        end
                        S_WAIT_LOCK: begin
                            r_to_cnt <= r_to_cnt + 1'b1;
                            if (r_lk[g]) begin
                                if (LOCK_STABLE_CYCLES == 1) begin
                                    r_state <= S_READY;
                                    r_ready <= 1'b1;
                                end else begin
                                    r_state <= S_STABLE;
                                    r_cnt   <= c_CW'(1);
                                end
                            end
                        end
                        S_STABLE: begin
                            r_to_cnt <= r_to_cnt + 1'b1;
                            if (!r_lk[g]) begin
                                r_state <= S_WAIT_LOCK;
                                r_cnt   <= '0;
                            end else if (r_cnt == c_CW'(LOCK_STABLE_CYCLES - 1)) begin
                                r_state <= S_READY;
                                r_ready <= 1'b1;
                            end else begin
                                r_cnt <= r_cnt + 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end

        assign pll_rst[g]                    = r_pll_rst;
        assign clk_ready[g]                  = r_ready;
        assign timeout_err[g]                = r_err;
        assign loss_count[g*CNT_W +: CNT_W]  = r_loss;
    end

    assign all_ready = &clk_ready;

endmodule
`default_nettype wire

// File: tb/tb_vid_pll_supervisor.sv
`default_nettype none
// ============================================================================
// Module      : tb_vid_pll_supervisor
// Description : Self-checking bench for vid_pll_supervisor. Directed start-up,
//               lock-loss, glitch, timeout, saturation and reset scenarios,
//               followed by randomized traffic, all compared every cycle
//               against a behavioural reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vid_pll_supervisor;

    localparam int NP = 2;
    localparam int RC = 4;
    localparam int LS = 8;
    localparam int LT = 32;
    localparam int CW = 2;

    logic                refclk = 1'b0;
    logic                rst = 1'b1;
    logic                err_clr = 1'b0;
    logic [NP-1:0]       pll_locked = '0;
    logic [NP-1:0]       relock_req = '0;
    logic [NP-1:0]       pll_rst;
    logic [NP-1:0]       clk_ready;
    logic                all_ready;
    logic [NP*CW-1:0]    loss_count;
    logic [NP-1:0]       timeout_err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 refclk = ~refclk;

    vid_pll_supervisor #(
        .NUM_PLLS            (NP),
        .RST_CYCLES          (RC),
        .LOCK_STABLE_CYCLES  (LS),
        .LOCK_TIMEOUT_CYCLES (LT),
        .CNT_W               (CW)
    ) dut (
        .refclk      (refclk),
        .rst         (rst),
        .pll_locked  (pll_locked),
        .relock_req  (relock_req),
        .err_clr     (err_clr),
        .pll_rst     (pll_rst),
        .clk_ready   (clk_ready),
        .all_ready   (all_ready),
        .loss_count  (loss_count),
        .timeout_err (timeout_err)
    );

    // Reference model: a channel is either in reset with hold_left cycles to
    // go, released and counting elapsed/consecutive-lock cycles, or ready.
    int m_hold   [NP];
    int m_wait   [NP];
    int m_streak [NP];
    int m_loss   [NP];
    bit m_ready  [NP];
    bit m_err    [NP];
    bit m_lkd1   [NP];   // raw locked delayed one cycle
    bit m_lk     [NP];   // raw locked delayed two cycles

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int ch = 0; ch < NP; ch++) begin
            m_hold[ch]   = RC;
            m_wait[ch]   = 0;
            m_streak[ch] = 0;
            m_loss[ch]   = 0;
            m_ready[ch]  = 1'b0;
            m_err[ch]    = 1'b0;
            m_lkd1[ch]   = 1'b0;
            m_lk[ch]     = 1'b0;
        end
    endtask

    task automatic model_edge();
        if (rst) begin
            model_reset();
            return;
        end
        for (int ch = 0; ch < NP; ch++) begin
            bit lk = m_lk[ch];
            bit rq = relock_req[ch];
            bit to = 1'b0;
            if (m_ready[ch]) begin
                if (!lk || rq) begin
                    m_ready[ch] = 1'b0;
                    m_hold[ch]  = RC;
                    if (!lk && m_loss[ch] < (1 << CW) - 1) m_loss[ch]++;
                end
            end else if (m_hold[ch] > 0) begin
                m_hold[ch]--;
                if (m_hold[ch] == 0) begin
                    m_wait[ch]   = 0;
                    m_streak[ch] = 0;
                end
            end else if (m_wait[ch] == LT - 1) begin
                to = 1'b1;
                m_hold[ch] = RC;
            end else if (rq) begin
                m_hold[ch] = RC;
            end else begin
                m_wait[ch]++;
                m_streak[ch] = lk ? m_streak[ch] + 1 : 0;
                if (m_streak[ch] == LS) m_ready[ch] = 1'b1;
            end
            if (to)           m_err[ch] = 1'b1;
            else if (err_clr) m_err[ch] = 1'b0;
            m_lk[ch]   = m_lkd1[ch];
            m_lkd1[ch] = pll_locked[ch];
        end
    endtask

    task automatic check_all();
        logic [NP-1:0]    e_rst, e_rdy, e_err;
        logic [NP*CW-1:0] e_loss;
        for (int ch = 0; ch < NP; ch++) begin
            e_rst[ch]            = (m_hold[ch] > 0) && !m_ready[ch];
            e_rdy[ch]            = m_ready[ch];
            e_err[ch]            = m_err[ch];
            e_loss[ch*CW +: CW]  = CW'(m_loss[ch]);
        end
        chk("pll_rst",     32'(pll_rst),     32'(e_rst));
        chk("clk_ready",   32'(clk_ready),   32'(e_rdy));
        chk("all_ready",   32'(all_ready),   32'(&e_rdy));
        chk("loss_count",  32'(loss_count),  32'(e_loss));
        chk("timeout_err", 32'(timeout_err), 32'(e_err));
    endtask

    task automatic step();
        @(posedge refclk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic run_until_ready(input int ch, input bit val, input string tag);
        int b = 0;
        while (m_ready[ch] != val && b < 100) begin
            step();
            b++;
        end
        chk(tag, 32'(b < 100), 32'd1);
    endtask

    task automatic run_until_streak(input int ch, input int val, input string tag);
        int b = 0;
        while (!(m_streak[ch] == val && m_hold[ch] == 0 && !m_ready[ch]) && b < 100) begin
            step();
            b++;
        end
        chk(tag, 32'(b < 100), 32'd1);
    endtask

    initial begin
        bit race_hit;
        model_reset();

        // Start-up
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (k <= 3) chk("startup_rst_held", 32'(pll_rst), 32'(2'b11));
            if (k == 4) chk("startup_rst_released", 32'(pll_rst), 32'(2'b00));
            if (k == 10) pll_locked = 2'b11;
            if (k == 19) chk("startup_not_yet_ready", 32'(clk_ready), 32'(2'b00));
        end
        chk("startup_ready", 32'(clk_ready), 32'(2'b11));
        chk("startup_all_ready", 32'(all_ready), 32'd1);

        // Lock loss on channel 1: one-cycle drop
        pll_locked = 2'b01;
        step();
        pll_locked = 2'b11;
        step();
        step();
        chk("loss_ready", 32'(clk_ready), 32'(2'b01));
        chk("loss_pll_rst", 32'(pll_rst), 32'(2'b10));
        chk("loss_count1", 32'(loss_count), 32'(4'b0100));
        run_until_ready(1, 1'b1, "loss_requalify");

        // Glitch during the stability window
        relock_req = 2'b11;
        step();
        relock_req = 2'b00;
        run_until_streak(0, 5, "glitch_reach_stable");
        pll_locked = 2'b10;
        step();
        pll_locked = 2'b11;
        run_until_ready(0, 1'b1, "glitch_requalify");
        chk("glitch_loss_unchanged", 32'(loss_count), 32'(4'b0100));

        // Timeout on channel 0
        rst = 1'b1;
        step();
        rst = 1'b0;
        pll_locked = 2'b10;
        for (int k = 1; k <= 36; k++) begin
            step();
            if (k == 35) chk("timeout_not_yet", 32'(timeout_err[0]), 32'd0);
        end
        chk("timeout_set", 32'(timeout_err[0]), 32'd1);
        chk("timeout_rehold", 32'(pll_rst[0]), 32'd1);
        step();
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("err_clr_clears", 32'(timeout_err[0]), 32'd0);
        race_hit = 1'b0;
        for (int k = 0; k < 80 && !race_hit; k++) begin
            if (m_hold[0] == 0 && !m_ready[0] && m_wait[0] == LT - 1) begin
                err_clr  = 1'b1;
                race_hit = 1'b1;
            end
            step();
            err_clr = 1'b0;
        end
        chk("race_reached", 32'(race_hit), 32'd1);
        chk("timeout_beats_clr", 32'(timeout_err[0]), 32'd1);

        // Five lock losses on channel 0, the first coinciding with relock_req
        pll_locked = 2'b11;
        for (int i = 0; i < 5; i++) begin
            run_until_ready(0, 1'b1, "sat_qualify");
            pll_locked[0] = 1'b0;
            step();
            pll_locked[0] = 1'b1;
            for (int b = 0; b < 10 && m_ready[0]; b++) begin
                relock_req[0] = (i == 0) && !m_lk[0];
                step();
                relock_req[0] = 1'b0;
            end
            if (i == 0) chk("coincide_counts_once", 32'(loss_count[CW-1:0]), 32'd1);
        end
        chk("loss_saturated", 32'(loss_count[CW-1:0]), 32'd3);

        // Reset while channel 0 is in the stability window
        run_until_streak(0, 3, "rst_reach_stable");
        rst = 1'b1;
        step();
        chk("rst_pll_rst", 32'(pll_rst), 32'(2'b11));
        chk("rst_clk_ready", 32'(clk_ready), 32'd0);
        chk("rst_all_ready", 32'(all_ready), 32'd0);
        chk("rst_loss", 32'(loss_count), 32'd0);
        chk("rst_err", 32'(timeout_err), 32'd0);
        rst = 1'b0;
        run_until_ready(0, 1'b1, "rst_requalify0");
        run_until_ready(1, 1'b1, "rst_requalify1");

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            for (int ch = 0; ch < NP; ch++) begin
                if ($urandom_range(0, 99) < 3) pll_locked[ch] = ~pll_locked[ch];
                relock_req[ch] = ($urandom_range(0, 99) < 2);
            end
            err_clr = ($urandom_range(0, 99) < 3);
            rst     = ($urandom_range(0, 999) < 2);
            step();
        end
        rst        = 1'b0;
        err_clr    = 1'b0;
        relock_req = '0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vid_pll_supervisor.md
# vid_pll_supervisor

Per-PLL lock supervisor for the video clocking subsystem. It sits beside one or more `altera_pll`-based video PLL wrappers and drives their `rst` inputs. It holds each PLL in reset at start-up, then qualifies each `locked` output over a stability window before declaring its clock usable. On lock loss, timeout or a software request it automatically re-locks the PLL, and it keeps per-PLL loss counters and sticky timeout flags.

## Interface
Parameters:
- `NUM_PLLS`, 1: number of supervised PLLs (channels), 1..8.
- `RST_CYCLES`, 16: cycles `pll_rst` is held high per reset attempt, ≥2.
- `LOCK_STABLE_CYCLES`, 1024: consecutive synchronized-locked cycles required before ready, ≥1.
- `LOCK_TIMEOUT_CYCLES`, 65536: maximum cycles allowed from `pll_rst` release to ready, > `LOCK_STABLE_CYCLES`.
- `CNT_W`, 8: width of each lock-loss counter.

Ports:
- `refclk`  in  1: free-running reference clock, the only clock in the block.
- `rst`  in  1: synchronous, active-high reset.
- `pll_locked`  in  `NUM_PLLS`: raw PLL `locked` outputs, asynchronous.
- `relock_req`  in  `NUM_PLLS`: single-cycle request to force a re-lock of the channel.
- `err_clr`  in  1: clears all `timeout_err` bits.
- `pll_rst`  out  `NUM_PLLS`: reset to each PLL, active-high.
- `clk_ready`  out  `NUM_PLLS`: channel clock qualified.
- `all_ready`  out  1: AND of all `clk_ready` bits.
- `loss_count`  out  `NUM_PLLS*CNT_W`: per-channel saturating lock-loss count; channel i occupies bits [i*CNT_W +: CNT_W].
- `timeout_err`  out  `NUM_PLLS`: sticky per-channel timeout flag.

## Operation
- Each `pll_locked` bit passes through a 2-flop synchronizer; `lk[i]` is the synchronized value. Every FSM decision uses `lk`.
- Each channel has an independent FSM with states HOLD, WAIT_LOCK, STABLE and READY.
- HOLD: `pll_rst`=1. The counter runs for `RST_CYCLES` cycles, then the FSM moves to WAIT_LOCK. The timeout counter is cleared on entry.
- WAIT_LOCK: `pll_rst`=0. If `lk`=1, go to STABLE with the stable counter at 1.
- STABLE: `lk`=1 increments the stable counter. When the count reaches `LOCK_STABLE_CYCLES`, go to READY. `lk`=0 returns the FSM to WAIT_LOCK and clears the stable counter.
- Timeout: the timeout counter runs in WAIT_LOCK and STABLE. When it reaches `LOCK_TIMEOUT_CYCLES`, the FSM sets `timeout_err[i]` and goes to HOLD (retry). Retries continue indefinitely.
- READY: `clk_ready`=1.
  - `lk`=0 → HOLD and `loss_count[i]` increments.
  - `relock_req[i]`=1 → HOLD without incrementing.
  - Both in the same cycle → one increment only.
- `relock_req` is ignored in HOLD. In WAIT_LOCK and STABLE it forces HOLD, with no count and no error.
- `loss_count` saturates at 2^`CNT_W`−1 and is cleared only by `rst`.
- `err_clr` clears every `timeout_err` bit. If a timeout occurs in the same cycle as `err_clr`, the set wins for that channel.

## Timing
- During `rst`: all FSMs are in HOLD, `pll_rst`=all ones, and `clk_ready`, `all_ready`, `loss_count`, `timeout_err` and the synchronizers are all zero.
- First cycle after `rst` falls: the HOLD count starts. `pll_rst` stays high for exactly `RST_CYCLES` cycles after `rst` deasserts.
- All outputs are registered, except `all_ready`, which is a combinational AND of registered `clk_ready`.
- Qualification latency: if raw `pll_locked` is stable high from cycle N, `clk_ready` rises at cycle N+2+`LOCK_STABLE_CYCLES`. This assumes the timeout is not hit first.
- Lock loss: if raw `pll_locked` falls at cycle N, then at cycle N+3 `clk_ready`=0, `pll_rst`=1 and `loss_count` is incremented.
- `relock_req` sampled at cycle N in READY gives `clk_ready`=0 and `pll_rst`=1 at N+1.
- `rst` mid-operation forces reset values on the next edge, regardless of FSM state.

## Test plan
Use `NUM_PLLS`=2, `RST_CYCLES`=4, `LOCK_STABLE_CYCLES`=8, `LOCK_TIMEOUT_CYCLES`=32, `CNT_W`=2.
- Start-up: release `rst`, assert `pll_locked`=2'b11 at cycle 10 → `pll_rst` falls after 4 cycles; `clk_ready`=2'b11 and `all_ready`=1 at cycle 20.
- Lock loss: drop `pll_locked[1]` for 1 cycle while READY → 3 cycles later `clk_ready[1]`=0 and `pll_rst[1]`=1 for 4 cycles; `loss_count[1]`=1; channel 0 unaffected.
- Glitch in STABLE: `pll_locked` low for 1 cycle after 5 stable cycles → no ready at the original time; ready 8 cycles after `lk` returns high; `loss_count` unchanged.
- Timeout: hold `pll_locked[0]`=0 → `timeout_err[0]`=1 at 32 cycles after `pll_rst` release, then `pll_rst[0]` re-asserts for 4 cycles. Pulse `err_clr` on the cycle of a second timeout → `timeout_err[0]` stays 1.
- Saturation and simultaneous events: 5 lock losses on channel 0, one of them coinciding with `relock_req[0]` → `loss_count[0]`=3 (saturated); the coinciding event counts once.
- Reset mid-STABLE: assert `rst` → next cycle all outputs at reset values; normal re-qualification follows.
